// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
package rf_wb_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int CNT_W  = 4;

  // Arbiter FSM: B idle, B being refused, B forced through
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } arb_state_e;

  // x0 is hard-wired to zero in the register file
  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Holds one busy bit per architectural register, produces the issue stall
// and a sticky error when B retires a register that was never marked busy.
// Optional: define RF_WB_SB_BYPASS_EN to let the register retired by the
// current B handshake count as ready in the same cycle (the falling-edge
// register-file write makes the value readable before the next rising edge).
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs,
  input  logic [AW-1:0] clr_addr,
  input  logic          iss_valid,
  input  logic          iss_long,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic          hold,
  output logic          iss_stall,
  output logic          sb_err
);

  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] busy_view_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] set_mask_s;
  logic            stall_s;
  logic            set_en_s;
  logic            sb_err_r;
  logic            err_nxt_s;

  assign clr_mask_s = hs ? (NREG'(1) << clr_addr) : '0;

`ifdef RF_WB_SB_BYPASS_EN
  assign busy_view_s = busy_r & ~clr_mask_s;
`else
  assign busy_view_s = busy_r;
`endif

  // Stall compare against the busy view, plus the arbiter's pipeline freeze
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s = hold ||
                (iss_valid && (busy_view_s[iss_rs1] || busy_view_s[iss_rs2] ||
                               (busy_view_s[iss_rd] && iss_long)));
    end
  end

  assign iss_stall  = stall_s;
  assign set_en_s   = iss_valid && !stall_s && iss_long && (iss_rd != ZERO_A);
  assign set_mask_s = set_en_s ? (NREG'(1) << iss_rd) : '0;

  // Next busy vector: clear first, so a same-cycle set of that register wins
  always_comb begin
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    err_nxt_s  = sb_err_r | (hs && !busy_r[clr_addr] && (clr_addr != ZERO_A));
  end

  // Busy bits and the sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= '0;
      sb_err_r <= 1'b0;
    end else begin
      busy_r   <= busy_nxt_s;
      sb_err_r <= err_nxt_s;
    end
  end

  assign sb_err = sb_err_r;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the in-order writeback (A) and the
// long-latency unit writeback (B). A normally wins; after STARVE_MAX refused
// cycles B is forced through while A is frozen with a_hold.
// Optional feature macro: RF_WB_SB_BYPASS_EN (same-cycle scoreboard bypass).
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  output logic          a_hold,
  input  logic          b_valid,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  output logic          b_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  input  logic          iss_valid,
  input  logic          iss_long,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  output logic          iss_stall,
  output logic          sb_err
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [AW-1:0]    ZERO_A     = AW'(REG_ZERO);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             grant_a_s;
  logic             grant_b_s;
  logic             hold_s;
  logic             hs_s;

  assign cnt_inc_s = cnt_r + 4'd1;

  // FSM state and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state, counter and grants
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    grant_a_s   = 1'b0;
    grant_b_s   = 1'b0;
    hold_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (a_valid) begin
          grant_a_s = 1'b1;
          if (b_valid) begin
            cnt_nxt_s   = 4'd1;
            state_nxt_s = (4'd1 >= STARVE_LIM) ? S_FORCE : S_WAIT;
          end else begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = S_IDLE;
          end
        end else begin
          grant_b_s   = b_valid;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!b_valid) begin
          // B withdrew its request
          grant_a_s   = a_valid;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = S_IDLE;
        end else if (a_valid) begin
          grant_a_s   = 1'b1;
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = (cnt_inc_s >= STARVE_LIM) ? S_FORCE : S_WAIT;
        end else begin
          grant_b_s   = 1'b1;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = S_IDLE;
        end
      end
      S_FORCE: begin
        // A is frozen; its request is granted from S_IDLE next cycle
        hold_s      = 1'b1;
        grant_b_s   = b_valid;
        cnt_nxt_s   = 4'd0;
        state_nxt_s = S_IDLE;
      end
      default: begin
        cnt_nxt_s   = 4'd0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Write mux; x0 grants are consumed without a write
  always_comb begin
    we = 1'b0;
    wa = a_wa;
    wd = a_wd;
    if (rst) begin
      we = 1'b0;
    end else if (grant_a_s) begin
      we = (a_wa != ZERO_A);
      wa = a_wa;
      wd = a_wd;
    end else if (grant_b_s) begin
      we = (b_wa != ZERO_A);
      wa = b_wa;
      wd = b_wd;
    end else begin
      we = 1'b0;
    end
  end

  assign b_ready = grant_b_s && !rst;
  assign a_hold  = hold_s && !rst;
  assign hs_s    = b_valid && b_ready;

  rf_scoreboard #(
    .AW(AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .hs       (hs_s),
    .clr_addr (b_wa),
    .iss_valid(iss_valid),
    .iss_long (iss_long),
    .iss_rd   (iss_rd),
    .iss_rs1  (iss_rs1),
    .iss_rs2  (iss_rs2),
    .hold     (a_hold),
    .iss_stall(iss_stall),
    .sb_err   (sb_err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SM = 4;

`ifdef RF_WB_SB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, iss_valid, iss_long;
  logic [AW-1:0] a_wa, b_wa, iss_rd, iss_rs1, iss_rs2;
  logic [DW-1:0] a_wd, b_wd;
  logic          a_hold, b_ready, we, iss_stall, sb_err;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_hold(a_hold),
    .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
    .we(we), .wa(wa), .wd(wd),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall), .sb_err(sb_err)
  );

  // Register file fed by the DUT write port, committing on the falling edge
  logic [DW-1:0] rf_mem [32];
  bit            rf_clear = 1'b1;
  always @(negedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (we === 1'b1) begin
      rf_mem[wa] <= wd;
    end
  end

  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] idx);
    return (idx == '0) ? '0 : rf_mem[idx];
  endfunction

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int refused    = 0;
  bit busy_m [32];
  bit err_m      = 1'b0;
  bit prev_force = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit busy_v(input logic [AW-1:0] r, input bit gb);
    return busy_m[r] && !(BYPASS && gb && (r == b_wa));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against the model, then advance the model one cycle
  task automatic cycle_check();
    bit            force_m, ga, gb, ewe, estall;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
    #3;
    if (rst) begin
      chk("rst_hold",   32'(a_hold),    32'd0);
      chk("rst_bready", 32'(b_ready),   32'd0);
      chk("rst_we",     32'(we),        32'd0);
      chk("rst_stall",  32'(iss_stall), 32'd0);
      chk("rst_sberr",  32'(sb_err),    32'd0);
      refused    = 0;
      err_m      = 1'b0;
      prev_force = 1'b0;
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    end else begin
      force_m = (refused >= SM);
      ga      = a_valid && !force_m;
      gb      = b_valid && (force_m || !a_valid);
      ewe     = ga ? (a_wa != '0) : (gb ? (b_wa != '0) : 1'b0);
      ewa     = ga ? a_wa : b_wa;
      ewd     = ga ? a_wd : b_wd;
      estall  = force_m || (iss_valid && (busy_v(iss_rs1, gb) || busy_v(iss_rs2, gb) ||
                                          (iss_long && busy_v(iss_rd, gb))));
      chk("hold",   32'(a_hold),    32'(force_m));
      chk("bready", 32'(b_ready),   32'(gb));
      chk("we",     32'(we),        32'(ewe));
      if (ewe) begin
        chk("wa", 32'(wa), 32'(ewa));
        chk("wd", wd, ewd);
      end
      chk("stall", 32'(iss_stall), 32'(estall));
      chk("sberr", 32'(sb_err),    32'(err_m));
      if (gb) begin
        if (!busy_m[b_wa] && (b_wa != '0)) err_m = 1'b1;
        busy_m[b_wa] = 1'b0;
      end
      if (iss_valid && !estall && iss_long && (iss_rd != '0)) busy_m[iss_rd] = 1'b1;
      if (force_m)                refused = 0;
      else if (a_valid && b_valid) refused++;
      else                        refused = 0;
      prev_force = force_m;
    end
  endtask

  function automatic logic [AW-1:0] pick_b();
    logic [AW-1:0] c;
    c = '0;
    for (int t = 0; t < 6; t++) begin
      c = AW'($urandom_range(0, 31));
      if (busy_m[c]) return c;
    end
    return c;
  endfunction

  initial begin
    bit keep_a;
    rst = 1'b1;
    a_valid = 1'b0; a_wa = '0; a_wd = '0;
    b_valid = 1'b0; b_wa = '0; b_wd = '0;
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    tick();
    rf_clear = 1'b0;

    // Reset with both requesters asserted
    a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'hA1A1_0003;
    b_valid = 1'b1; b_wa = 5'd4; b_wd = 32'hB0B0_0004;
    iss_valid = 1'b1; iss_rs1 = 5'd4;
    cycle_check();
    chk("dir_rst_we", 32'(we), 32'd0);
    chk("dir_rst_bready", 32'(b_ready), 32'd0);
    tick();
    rst = 1'b0; iss_valid = 1'b0;
    cycle_check();
    chk("dir_first_a_we", 32'(we), 32'd1);
    chk("dir_first_a_wa", 32'(wa), 32'd3);
    chk("dir_first_b_refused", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    cycle_check(); tick();

    // Long issue to x5 (and x12 for later), RAW stall, release by B writeback
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd5; iss_rs1 = '0; iss_rs2 = '0;
    cycle_check();
    chk("dir_iss5_nostall", 32'(iss_stall), 32'd0);
    tick();
    iss_rd = 5'd12;
    cycle_check(); tick();
    iss_long = 1'b0; iss_rd = 5'd6; iss_rs1 = 5'd5;
    cycle_check();
    chk("dir_raw_stall", 32'(iss_stall), 32'd1);
    tick();
    cycle_check(); tick();
    b_valid = 1'b1; b_wa = 5'd5; b_wd = 32'hDEAD_BEEF;
    cycle_check();
    chk("dir_b5_ready", 32'(b_ready), 32'd1);
    chk("dir_b5_we", 32'(we), 32'd1);
    chk("dir_b5_stall", 32'(iss_stall), 32'(!BYPASS));
    tick();
    b_valid = 1'b0;
    chk("dir_rf5", rf_read(5'd5), 32'hDEAD_BEEF);
    cycle_check();
    chk("dir_stall_clear", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 1'b0;

    // Starvation: A every cycle, B continuous, then forced B write
    a_valid = 1'b1; b_valid = 1'b1; b_wa = 5'd12; b_wd = 32'hCAFE_0012;
    for (int i = 0; i < SM; i++) begin
      a_wa = AW'(16 + i); a_wd = 32'h0000_1000 + 32'(i);
      cycle_check();
      chk("dir_starve_bready", 32'(b_ready), 32'd0);
      chk("dir_starve_hold", 32'(a_hold), 32'd0);
      tick();
    end
    a_wa = 5'd20; a_wd = 32'h0000_A0A0;
    cycle_check();
    chk("dir_force_hold", 32'(a_hold), 32'd1);
    chk("dir_force_we", 32'(we), 32'd1);
    chk("dir_force_wa", 32'(wa), 32'd12);
    tick();
    b_valid = 1'b0;
    cycle_check();
    chk("dir_held_a_wa", 32'(wa), 32'd20);
    chk("dir_held_a_hold", 32'(a_hold), 32'd0);
    tick();
    chk("dir_rf12", rf_read(5'd12), 32'hCAFE_0012);
    chk("dir_rf20", rf_read(5'd20), 32'h0000_A0A0);
    chk("dir_rf19", rf_read(5'd19), 32'h0000_1003);

    // A write to x0 is dropped
    a_wa = '0; a_wd = 32'h0000_1234;
    cycle_check();
    chk("dir_x0_we", 32'(we), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("dir_x0_mem", rf_mem[0], 32'd0);

    // B retires a register that was never busy
    b_valid = 1'b1; b_wa = 5'd7; b_wd = 32'h0000_0077;
    cycle_check(); tick();
    b_valid = 1'b0;
    cycle_check();
    chk("dir_sberr_set", 32'(sb_err), 32'd1);
    tick();

    // Same-cycle clear and set of x9: set wins
    b_valid = 1'b1; b_wa = 5'd9; b_wd = 32'h0000_0099;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9; iss_rs1 = '0; iss_rs2 = '0;
    cycle_check(); tick();
    b_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd1; iss_rs1 = 5'd9;
    cycle_check();
    chk("dir_x9_busy", 32'(iss_stall), 32'd1);
    chk("dir_sberr_sticky", 32'(sb_err), 32'd1);
    tick();
    iss_valid = 1'b0;
    rst = 1'b1;
    cycle_check(); tick();
    rst = 1'b0;
    cycle_check();
    chk("dir_sberr_cleared", 32'(sb_err), 32'd0);
    tick();

    // Randomized traffic with occasional mid-run resets
    for (int n = 0; n < 2000; n++) begin
      keep_a = (refused >= SM) || prev_force;
      rst = ($urandom_range(0, 99) == 0);
      if (!keep_a) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_wa    = AW'($urandom_range(0, 31));
        a_wd    = $urandom;
      end
      b_valid   = ($urandom_range(0, 99) < 40);
      b_wa      = pick_b();
      b_wd      = $urandom;
      iss_valid = ($urandom_range(0, 99) < 50);
      iss_long  = ($urandom_range(0, 99) < 40);
      iss_rd    = AW'($urandom_range(0, 31));
      iss_rs1   = AW'($urandom_range(0, 31));
      iss_rs2   = AW'($urandom_range(0, 31));
      cycle_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
